// File: rtl/vote_pkg.sv
// Shared definitions for the voter input conditioning slice.
//   N_IN          number of voter inputs; bit order {e,d,c,b,a} = [4:0]
//   A_IDX..E_IDX  bit positions of the individual voter inputs
//   out_state_e   states of the output handshake FSM
package vote_pkg;

  localparam int N_IN = 5;

  localparam int A_IDX = 0;
  localparam int B_IDX = 1;
  localparam int C_IDX = 2;
  localparam int D_IDX = 3;
  localparam int E_IDX = 4;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    PEND = 2'd2
  } out_state_e;

endpackage

// File: rtl/vote_debounce_bit.sv
// One input bit of the voter front-end: a SYNC_STAGES-deep synchroniser
// followed by a debounce counter that accepts a new level only after it
// has been seen on DB_CYCLES consecutive sample ticks.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   raw        asynchronous raw input bit
//   sample_en  debounce sample tick; the synchroniser runs regardless
//   deb        debounced (held) level
module vote_debounce_bit
  import vote_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic sample_en,
  output logic deb
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syn;
  logic [DB_CNT_W-1:0]    cnt_q;
  logic                   deb_q;

  // Synchroniser: shift raw through SYNC_STAGES flops; the MSB is the
  // metastability-resolved copy used by the debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign syn = sync_q[SYNC_STAGES-1];

  // Debounce: count consecutive disagreeing ticks; any agreeing tick
  // restarts the count, so a glitch shorter than DB_CYCLES ticks is lost.
  // The counter stops at CNT_LAST and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (sample_en) begin
      if (syn == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= syn;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/vote_input_conditioner.sv
// Front-end of the 5-input majority/override voter. Synchronises and
// debounces each raw input, then offers the stable vector to the voter
// through a valid/ready handshake, together with the bits that changed
// since the last accepted vector and a count of changes absorbed while a
// vector sat unaccepted.
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   raw_in        asynchronous raw inputs {e,d,c,b,a}
//   sample_en     debounce sample tick (tie 1 to sample every cycle)
//   out_vec       stable vector to the voter, meaningful while out_valid
//   out_valid     out_vec holds a new vector
//   out_ready     consumer accepts; handshake when out_valid & out_ready
//   changed_mask  out_vec XOR previously accepted vector
//   missed_cnt    saturating count of debounced changes absorbed while pending
module vote_input_conditioner
  import vote_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 8,
  parameter int DB_CYCLES   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  input  logic            sample_en,
  output logic [N_IN-1:0] out_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] changed_mask,
  output logic [7:0]      missed_cnt
);

  localparam int                  FL_W       = $clog2(SYNC_STAGES + 1);
  localparam logic [FL_W-1:0]     FLUSH_LAST = FL_W'(SYNC_STAGES);
  localparam logic [DB_CNT_W-1:0] INIT_LAST  = DB_CNT_W'(DB_CYCLES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [N_IN-1:0]     deb;
  logic [N_IN-1:0]     deb_prev_q;
  logic [FL_W-1:0]     flush_cnt_q;
  logic [DB_CNT_W-1:0] init_cnt_q;
  out_state_e          state_q;
  out_state_e          state_d;

  logic hs;
  logic deb_diff;
  logic deb_moved;
  logic flush_done;
  logic init_done;

  logic load_vec;
  logic mask_from_deb;
  logic clr_valid;
  logic count_miss;
  logic init_tick;

  // ---- Stage: per-bit synchronise + debounce ----
  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    vote_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT_W    (DB_CNT_W),
      .DB_CYCLES   (DB_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (raw_in[i]),
      .sample_en (sample_en),
      .deb       (deb[i])
    );
  end

  // ---- Stage: output FSM and presentation registers ----
  assign hs         = out_valid & out_ready;
  assign deb_diff   = (deb != out_vec);
  assign deb_moved  = (deb != deb_prev_q);
  assign flush_done = (flush_cnt_q == FLUSH_LAST);
  assign init_done  = (init_cnt_q == INIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_done) state_d = PEND;
      IDLE:    if (deb_diff) state_d = PEND;
      PEND:    if (hs && !deb_diff) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // In PEND a handshake with a newer debounced vector reloads in the same
  // cycle, so back-to-back vectors go out without a bubble.
  always_comb begin
    load_vec      = 1'b0;
    mask_from_deb = 1'b0;
    clr_valid     = 1'b0;
    count_miss    = 1'b0;
    init_tick     = 1'b0;
    case (state_q)
      INIT: begin
        if (init_done) begin
          load_vec      = 1'b1;
          mask_from_deb = 1'b1;
        end else if (flush_done && sample_en) begin
          init_tick = 1'b1;
        end
      end
      IDLE: begin
        if (deb_diff) load_vec = 1'b1;
      end
      PEND: begin
        if (hs) begin
          if (deb_diff) load_vec = 1'b1;
          else          clr_valid = 1'b1;
        end else if (deb_moved) begin
          count_miss = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The INIT count only starts once the synchroniser has been refilled
  // after reset, so it lines up with the debouncers' own first ticks and
  // the startup vector is the settled input level rather than the
  // reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q  <= '0;
      init_cnt_q   <= '0;
      deb_prev_q   <= '0;
      out_vec      <= '0;
      changed_mask <= '0;
      out_valid    <= 1'b0;
      missed_cnt   <= '0;
    end else begin
      deb_prev_q <= deb;
      if (!flush_done) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (init_tick)   init_cnt_q  <= init_cnt_q + 1'b1;
      if (load_vec) begin
        out_vec      <= deb;
        changed_mask <= mask_from_deb ? deb : (deb ^ out_vec);
        out_valid    <= 1'b1;
      end else if (clr_valid) begin
        out_valid <= 1'b0;
      end
      if (count_miss) missed_cnt <= sat_inc8(missed_cnt);
    end
  end

endmodule

// File: tb/tb_vote_input_conditioner.sv
module tb_vote_input_conditioner;
  import vote_pkg::*;

  localparam int SYNC = 2;
  localparam int DBC  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_IN-1:0] raw_in = '0;
  logic            sample_en = 1'b1;
  logic [N_IN-1:0] out_vec;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N_IN-1:0] changed_mask;
  logic [7:0]      missed_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit se_div4 = 1'b0;
  int cyc     = 0;

  vote_input_conditioner #(
    .SYNC_STAGES (SYNC),
    .DB_CNT_W    (8),
    .DB_CYCLES   (DBC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_in       (raw_in),
    .sample_en    (sample_en),
    .out_vec      (out_vec),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .changed_mask (changed_mask),
    .missed_cnt   (missed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!out_valid && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Sample tick generator: every cycle, or every 4th cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      sample_en = se_div4 ? (cyc % 4 == 0) : 1'b1;
    end
  end

  // ---------------- behavioural model ----------------
  // Inputs reach the debouncer SYNC edges late; a bit's held level flips
  // once the last DBC sampled synchroniser values all disagree with it.
  logic [N_IN-1:0] m_pipe [SYNC];
  logic [N_IN-1:0] m_hist [DBC];
  logic [N_IN-1:0] m_s, m_s_prev, m_syn;
  logic [N_IN-1:0] m_out, m_mask;
  bit              m_valid, m_hs, m_all;
  int              m_phase;  // 0 startup, 1 waiting for change, 2 presenting
  int              m_edge, m_init_ticks, m_missed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
      for (int k = 0; k < DBC; k++)  m_hist[k] = '0;
      m_s = '0; m_s_prev = '0; m_out = '0; m_mask = '0;
      m_valid = 0; m_phase = 0; m_edge = 0; m_init_ticks = 0; m_missed = 0;
    end else begin
      m_edge++;
      m_hs = m_valid && out_ready;
      if (m_phase == 0) begin
        if (m_init_ticks == DBC) begin
          m_out = m_s; m_mask = m_s; m_valid = 1; m_phase = 2;
        end else if (m_edge > SYNC && sample_en) begin
          m_init_ticks++;
        end
      end else if (m_phase == 1) begin
        if (m_s != m_out) begin
          m_mask = m_s ^ m_out; m_out = m_s; m_valid = 1; m_phase = 2;
        end
      end else begin
        if (m_hs) begin
          if (m_s != m_out) begin
            m_mask = m_s ^ m_out; m_out = m_s;
          end else begin
            m_valid = 0; m_phase = 1;
          end
        end else if (m_s != m_s_prev && m_missed < 255) begin
          m_missed++;
        end
      end
      m_s_prev = m_s;
      m_syn = m_pipe[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = raw_in;
      if (sample_en) begin
        for (int k = 0; k < DBC - 1; k++) m_hist[k] = m_hist[k+1];
        m_hist[DBC-1] = m_syn;
        for (int b = 0; b < N_IN; b++) begin
          m_all = 1;
          for (int k = 0; k < DBC; k++) if (m_hist[k][b] == m_s[b]) m_all = 0;
          if (m_all) m_s[b] = ~m_s[b];
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit              c_prev_valid = 0, c_prev_ready = 0;
  logic [N_IN-1:0] c_prev_vec = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", out_valid, m_valid);
      check("missed", missed_cnt, m_missed);
      if (m_valid) begin
        check("vec", out_vec, m_out);
        check("mask", changed_mask, m_mask);
      end
      if (c_prev_valid && !c_prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_vec", out_vec, c_prev_vec);
      end
      c_prev_valid = out_valid;
      c_prev_ready = out_ready;
      c_prev_vec   = out_vec;
    end else begin
      c_prev_valid = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  int n;

  initial begin
    raw_in = 5'b10101;
    step(3);
    check("rst_valid", out_valid, 0);
    check("rst_vec", out_vec, 0);
    check("rst_mask", changed_mask, 0);
    check("rst_missed", missed_cnt, 0);
    rst_n = 1'b1;

    // Startup: 2 synchroniser + 16 debounce edges, then the vector register.
    wait_valid(100, n);
    check_rng("init_latency", n, 18, 19);
    check("init_vec", out_vec, 5'b10101);
    check("init_mask", changed_mask, 5'b10101);
    out_ready = 1'b1; step(1); out_ready = 1'b0;
    check("init_ack", out_valid, 0);

    raw_in = 5'b00000;
    wait_valid(100, n);
    check("zero_vec", out_vec, 5'b00000);
    check("zero_mask", changed_mask, 5'b10101);
    out_ready = 1'b1; step(1); out_ready = 1'b0;

    // Glitch of 10 ticks on input c must be rejected.
    raw_in[C_IDX] = 1'b1; step(10); raw_in[C_IDX] = 1'b0; step(30);
    check("glitch_valid", out_valid, 0);
    check("glitch_missed", missed_cnt, 0);

    // Clean change on input d, left pending.
    raw_in = 5'b01000;
    wait_valid(100, n);
    check_rng("clean_latency", n, 18, 19);
    check("clean_vec", out_vec, 5'b01000);
    check("clean_mask", changed_mask, 5'b01000);

    // Backpressure: two settled changes absorbed while pending.
    raw_in = 5'b00001; step(30);
    raw_in = 5'b00011; step(30);
    check("bp_valid", out_valid, 1);
    check("bp_frozen", out_vec, 5'b01000);
    check("bp_missed", missed_cnt, 2);
    out_ready = 1'b1; step(1);
    check("bp_reload_vec", out_vec, 5'b00011);
    check("bp_reload_mask", changed_mask, 5'b01011);
    check("bp_reload_valid", out_valid, 1);
    step(1); out_ready = 1'b0;
    check("bp_drain", out_valid, 0);

    // Sample tick every 4th cycle: settling stretches to ~2 + 64 cycles.
    se_div4 = 1'b1;
    raw_in = 5'b00111;
    wait_valid(200, n);
    check_rng("div4_latency", n, 62, 70);
    check("div4_vec", out_vec, 5'b00111);
    check("div4_mask", changed_mask, 5'b00100);

    // Reset while pending: outputs clear at once.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_vec", out_vec, 0);
    check("arst_missed", missed_cnt, 0);
    se_div4 = 1'b0;
    raw_in = 5'b00000;
    step(3);
    check("arst_hold", out_valid, 0);
    rst_n = 1'b1;
    wait_valid(100, n);
    check_rng("reinit_latency", n, 18, 19);
    check("reinit_vec", out_vec, 5'b00000);
    check("reinit_mask", changed_mask, 5'b00000);

    // Saturation: 300 settled changes while stalled.
    for (int i = 0; i < 300; i++) begin
      raw_in[A_IDX] = ~raw_in[A_IDX];
      step(20);
    end
    check("sat_missed", missed_cnt, 255);
    check("sat_valid", out_valid, 1);
    check("sat_vec", out_vec, 5'b00000);
    out_ready = 1'b1; step(1); out_ready = 1'b0;
    check("sat_drain", out_valid, 0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
